// File: rtl/fifo_pkg.sv
// Shared types and constants for the single-clock FIFO: pointer-width helper,
// a packed status word for monitoring blocks, and status reset values.
package fifo_pkg;

    // Address width for a DEPTH-entry array; never returns less than one bit.
    function automatic int clog2_safe(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    typedef struct packed {
        logic f_flag;
        logic e_flag;
        logic almost_full_flag;
        logic almost_empty_flag;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    localparam logic RST_F_FLAG            = 1'b0;
    localparam logic RST_E_FLAG            = 1'b1;
    localparam logic RST_ALMOST_FULL_FLAG  = 1'b0;
    localparam logic RST_ALMOST_EMPTY_FLAG = 1'b1;
    localparam logic RST_OVERFLOW          = 1'b0;
    localparam logic RST_UNDERFLOW         = 1'b0;

    localparam fifo_status_t FIFO_STATUS_RST = '{
        f_flag:            RST_F_FLAG,
        e_flag:            RST_E_FLAG,
        almost_full_flag:  RST_ALMOST_FULL_FLAG,
        almost_empty_flag: RST_ALMOST_EMPTY_FLAG,
        overflow:          RST_OVERFLOW,
        underflow:         RST_UNDERFLOW
    };

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int DEPTH = 16,
    localparam int AW   = clog2_safe(DEPTH)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [SIZE-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [SIZE-1:0] o_rdata
);

    logic [SIZE-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, registered threshold flags and sticky
// error flags. Define FIFO_FWFT_EN for first-word-fall-through read behaviour.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int SIZE     = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SIZE-1:0]        data_in,
    input  logic                   valid_write,
    input  logic                   valid_read,
    output logic [SIZE-1:0]        data_out,
    output logic                   data_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   f_flag,
    output logic                   e_flag,
    output logic                   almost_full_flag,
    output logic                   almost_empty_flag,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = clog2_safe(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    fifo_status_t    r_status;
    fifo_status_t    w_status_next;
    logic            w_rd_ok;
    logic            w_wr_ok;
    logic [SIZE-1:0] w_rd_data;

    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign w_rd_ok = valid_read && !r_status.e_flag;
    assign w_wr_ok = valid_write && (!r_status.f_flag || w_rd_ok);

    always_comb begin
        w_count_next = r_count;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_wr_ok && w_rd_ok) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_comb begin
        w_status_next                   = r_status;
        w_status_next.f_flag            = (w_count_next == DEPTH_C);
        w_status_next.e_flag            = (w_count_next == '0);
        w_status_next.almost_full_flag  = (w_count_next >= AF_C);
        w_status_next.almost_empty_flag = (w_count_next <= AE_C);
        w_status_next.overflow          = r_status.overflow  || (valid_write && !w_wr_ok);
        w_status_next.underflow         = r_status.underflow || (valid_read  && !w_rd_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_status <= FIFO_STATUS_RST;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count  <= w_count_next;
            r_status <= w_status_next;
        end
    end

    fifo_mem #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; valid_read acknowledges and pops it.
    assign data_out   = w_rd_data;
    assign data_valid = !r_status.e_flag;
`else
    logic [SIZE-1:0] r_data_out;
    logic            r_data_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
`endif

    assign count             = r_count;
    assign f_flag            = r_status.f_flag;
    assign e_flag            = r_status.e_flag;
    assign almost_full_flag  = r_status.almost_full_flag;
    assign almost_empty_flag = r_status.almost_empty_flag;
    assign overflow          = r_status.overflow;
    assign underflow         = r_status.underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DEPTH 16, AF 14, AE 2); a queue scoreboard
// tracks expected read data. Works in both standard and FIFO_FWFT_EN builds.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_write;
    logic       valid_read;
    logic [7:0] data_out;
    logic       data_valid;
    logic [4:0] count;
    logic       f_flag, e_flag, almost_full_flag, almost_empty_flag;
    logic       overflow, underflow;

    sync_fifo #(.SIZE(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .data_in           (data_in),
        .valid_write       (valid_write),
        .valid_read        (valid_read),
        .data_out          (data_out),
        .data_valid        (data_valid),
        .count             (count),
        .f_flag            (f_flag),
        .e_flag            (e_flag),
        .almost_full_flag  (almost_full_flag),
        .almost_empty_flag (almost_empty_flag),
        .overflow          (overflow),
        .underflow         (underflow)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         m_count;
    bit         m_ovf, m_unf;
    logic [7:0] m_last;
    logic [7:0] exp_q [$];

    // One clock of stimulus; scoreboard pops on an accepted read and compares
    // the emerging word, then the observed status is compared with the model.
    task automatic xfer(input bit w, input logic [7:0] d, input bit r);
        bit         rd_ok, wr_ok;
        logic [7:0] exp_d;
        logic [10:0] exp_st, act_st;
        exp_d = 8'h00;
        rd_ok = r && (m_count != 0);
        wr_ok = w && ((m_count != 16) || rd_ok);
        valid_write = w;
        data_in     = d;
        valid_read  = r;
        if (rd_ok) exp_d = exp_q.pop_front();
`ifdef FIFO_FWFT_EN
        if (rd_ok) begin
            n_checks++;
            if (data_out !== exp_d || data_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL fwft_head data_out=%0d valid=%b required %0d valid=1", data_out, data_valid, exp_d);
            end
            m_last = exp_d;
        end
`endif
        if (wr_ok) exp_q.push_back(d);
        @(posedge clk);
        #1;
        valid_write = 1'b0;
        valid_read  = 1'b0;
        m_count = m_count + int'(wr_ok) - int'(rd_ok);
        m_ovf   = m_ovf | (w && !wr_ok);
        m_unf   = m_unf | (r && !rd_ok);
`ifdef FIFO_FWFT_EN
        n_checks++;
        if (data_valid !== (m_count != 0)) begin
            n_errors++;
            $display("FAIL fwft_valid data_valid=%b required %b", data_valid, (m_count != 0));
        end
`else
        n_checks++;
        if (rd_ok) begin
            m_last = exp_d;
            if (data_valid !== 1'b1 || data_out !== exp_d) begin
                n_errors++;
                $display("FAIL rd_data data_out=%0d valid=%b required %0d valid=1", data_out, data_valid, exp_d);
            end
        end else if (data_valid !== 1'b0 || data_out !== m_last) begin
            n_errors++;
            $display("FAIL rd_hold data_out=%0d valid=%b required %0d valid=0", data_out, data_valid, m_last);
        end
`endif
        exp_st = {5'(m_count), (m_count == 16), (m_count == 0), (m_count >= 14), (m_count <= 2), m_ovf, m_unf};
        act_st = {count, f_flag, e_flag, almost_full_flag, almost_empty_flag, overflow, underflow};
        n_checks++;
        if (act_st !== exp_st) begin
            n_errors++;
            $display("FAIL status cnt/f/e/af/ae/ov/un=%b required %b", act_st, exp_st);
        end
        $display("xfer w=%b d=%0d r=%b -> count=%0d data_out=%0d valid=%b", w, d, r, count, data_out, data_valid);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_count = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_last  = 8'h00;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count %0d required 0", count); end
        n_checks++; if (e_flag !== 1'b1) begin n_errors++; $display("FAIL reset_e_flag %b required 1", e_flag); end
        n_checks++; if (almost_empty_flag !== 1'b1) begin n_errors++; $display("FAIL reset_ae %b required 1", almost_empty_flag); end
        n_checks++;
        if ({f_flag, almost_full_flag, overflow, underflow, data_valid} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags f/af/ov/un/dv=%b required 00000", {f_flag, almost_full_flag, overflow, underflow, data_valid});
        end
`ifndef FIFO_FWFT_EN
        n_checks++; if (data_out !== 8'd0) begin n_errors++; $display("FAIL reset_data_out %0d required 0", data_out); end
`endif
        $display("test_reset done");
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            xfer(1'b1, 8'(i), 1'b0);
            if (i == 12) begin
                n_checks++; if (almost_full_flag !== 1'b0) begin n_errors++; $display("FAIL af_at13 %b required 0", almost_full_flag); end
            end
            if (i == 13) begin
                n_checks++; if (almost_full_flag !== 1'b1) begin n_errors++; $display("FAIL af_at14 %b required 1", almost_full_flag); end
            end
            if (i == 14) begin
                n_checks++; if (f_flag !== 1'b0) begin n_errors++; $display("FAIL f_at15 %b required 0", f_flag); end
            end
        end
        n_checks++; if (f_flag !== 1'b1) begin n_errors++; $display("FAIL f_at16 %b required 1", f_flag); end
        xfer(1'b1, 8'd99, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL fill_overflow %b required 1", overflow); end
        n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL fill_count %0d required 16", count); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) xfer(1'b0, 8'd0, 1'b1);
        n_checks++; if (e_flag !== 1'b1) begin n_errors++; $display("FAIL drain_e_flag %b required 1", e_flag); end
        xfer(1'b0, 8'd0, 1'b1);
        n_checks++; if (underflow !== 1'b1) begin n_errors++; $display("FAIL drain_underflow %b required 1", underflow); end
`ifndef FIFO_FWFT_EN
        n_checks++; if (data_out !== 8'd15) begin n_errors++; $display("FAIL drain_hold %0d required 15", data_out); end
`endif
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 16; i++) xfer(1'b1, 8'(100 + i), 1'b0);
        xfer(1'b1, 8'd42, 1'b1);
        n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL full_rw_count %0d required 16", count); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL full_rw_overflow %b required 0", overflow); end
        for (int i = 0; i < 15; i++) xfer(1'b0, 8'd0, 1'b1);
`ifdef FIFO_FWFT_EN
        n_checks++; if (data_out !== 8'd42) begin n_errors++; $display("FAIL last_word %0d required 42", data_out); end
        xfer(1'b0, 8'd0, 1'b1);
`else
        xfer(1'b0, 8'd0, 1'b1);
        n_checks++; if (data_out !== 8'd42) begin n_errors++; $display("FAIL last_word %0d required 42", data_out); end
`endif
        xfer(1'b1, 8'd7, 1'b1);
        n_checks++; if (count !== 5'd1) begin n_errors++; $display("FAIL empty_rw_count %0d required 1", count); end
        n_checks++; if (underflow !== 1'b1) begin n_errors++; $display("FAIL empty_rw_underflow %b required 1", underflow); end
        xfer(1'b0, 8'd0, 1'b1);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) xfer(1'b1, 8'(200 + i), 1'b0);
        for (int i = 0; i < 40; i++) xfer(1'b1, 8'(i * 3 + 1), 1'b1);
        n_checks++; if (count !== 5'd3) begin n_errors++; $display("FAIL wrap_count %0d required 3", count); end
        for (int i = 0; i < 3; i++) xfer(1'b0, 8'd0, 1'b1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 17; i++) xfer(1'b1, 8'(i + 60), 1'b0);
        for (int i = 0; i < 9; i++) xfer(1'b0, 8'd0, 1'b1);
        n_checks++; if (count !== 5'd7) begin n_errors++; $display("FAIL pre_rst_count %0d required 7", count); end
        do_reset();
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL mid_rst_count %0d required 0", count); end
        n_checks++; if (e_flag !== 1'b1) begin n_errors++; $display("FAIL mid_rst_e_flag %b required 1", e_flag); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL mid_rst_overflow %b required 0", overflow); end
        xfer(1'b1, 8'd5, 1'b0);
`ifdef FIFO_FWFT_EN
        n_checks++; if (data_out !== 8'd5) begin n_errors++; $display("FAIL post_rst_word %0d required 5", data_out); end
        xfer(1'b0, 8'd0, 1'b1);
`else
        xfer(1'b0, 8'd0, 1'b1);
        n_checks++; if (data_out !== 8'd5) begin n_errors++; $display("FAIL post_rst_word %0d required 5", data_out); end
`endif
    endtask

    initial begin
        rst         = 1'b1;
        data_in     = 8'd0;
        valid_write = 1'b0;
        valid_read  = 1'b0;
        m_count     = 0;
        m_ovf       = 1'b0;
        m_unf       = 1'b0;
        m_last      = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO; the successor to the team's dual-clock FIFO for paths where producer and consumer share one clock. It adds a read handshake, programmable almost-full and almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. An optional first-word-fall-through mode is selected at compile time. It sits between any same-domain producer/consumer pair in the datapath.

## Interface
- SIZE, 8, data word width in bits
- DEPTH, 16, number of entries; power of two, ≥ 2
- AF_LEVEL, 14, almost_full_flag asserts when count ≥ AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 2, almost_empty_flag asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  SIZE  write data
- valid_write  in  1  write request
- valid_read  in  1  read request
- data_out  out  SIZE  read data
- data_valid  out  1  data_out holds a valid word
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- f_flag  out  1  count == DEPTH
- e_flag  out  1  count == 0
- almost_full_flag  out  1  count ≥ AF_LEVEL
- almost_empty_flag  out  1  count ≤ AE_LEVEL
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Read accepted (rd_ok) = valid_read && !e_flag.
- Write accepted (wr_ok) = valid_write && (!f_flag || rd_ok). When full, a simultaneous read and write both succeed.
- When empty, a simultaneous read and write: the read is rejected and underflow is set; the write proceeds.
- Pointers wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Count update: count_next = count + wr_ok − rd_ok. Count never leaves 0..DEPTH.
- Flags are registered. Each flag is computed from count_next and updates on the same edge as count.
- overflow is set on valid_write && !wr_ok. underflow is set on valid_read && !rd_ok. Both are cleared only by rst.
- Memory contents are not reset. A rejected write does not modify memory.

## Timing
- Values at rst: pointers 0; count 0; e_flag 1; f_flag 0; almost_full_flag 0; almost_empty_flag 1; overflow 0; underflow 0; data_out 0; data_valid 0.
- rst mid-operation discards all stored words. Outputs take reset values on the next edge.
- Write-to-flag latency is one cycle: a write at edge N raises count and clears e_flag after edge N.
- Standard mode read latency is one cycle: rd_ok at edge N puts the head word on data_out after edge N, with data_valid high for exactly that cycle. data_out holds its value when no read occurs.
- A word written at edge N is readable with valid_read sampled at edge N+1 at the earliest.

## Configuration
- FIFO_FWFT_EN defined (first-word fall-through):
  - data_out = mem[rd_ptr] and data_valid = !e_flag, both combinational from registered state.
  - valid_read acts as an acknowledge and pops the head word at the edge.
  - A word written at edge N is visible on data_out after edge N.
- FIFO_FWFT_EN undefined: standard mode as described under Timing.
- Flag, count and error behaviour is identical in both modes.

## Structure
- Package fifo_pkg:
  - Function clog2_safe, returning 1 for DEPTH ≤ 2.
  - Typedef fifo_status_t packing f_flag, e_flag, almost_full_flag, almost_empty_flag, overflow and underflow, for monitoring blocks.
  - Reset-value constants for the above.
- Sub-module fifo_mem: simple dual-port register array with one write port and one asynchronous read port, parametrised by SIZE and DEPTH.
- Top level holds the pointers, count, flag logic, error logic and the data_out register.

## Test plan
- Reset then idle: after rst, e_flag = 1, almost_empty_flag = 1, count = 0, data_out = 0, and all other flags are 0.
- Fill test:
  - Write 0..15 with valid_read low. f_flag rises after the 16th write, and almost_full_flag rises after the 14th.
  - A 17th write of value 99 sets overflow; count stays 16.
- Drain test:
  - Read 16 times; data_out sequence is 0..15 (one cycle after each read in standard mode). e_flag rises after the last read.
  - One extra read sets underflow and leaves data_out at 15.
- Simultaneous access:
  - When full, write 42 and read in the same cycle: count stays 16, no overflow, and 42 emerges last.
  - When empty, write plus read: count becomes 1 and underflow is set.
- Wrap-around: run 40 interleaved writes and reads with 3-deep occupancy. The output matches the write order across pointer wrap.
- Reset mid-stream:
  - With count = 7, assert rst for one cycle: count = 0, e_flag = 1, overflow = 0.
  - A following write of 5 then a read returns 5.
  - Repeat all scenarios with FIFO_FWFT_EN defined and check zero-cycle read visibility.
